// File: rtl/inst_fetch_stage.sv
// Instruction fetch stage: sequential PC generation, single-outstanding reads on the
// SRAM-like instruction port, and a one-entry instruction buffer toward decode.
module inst_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,
    output logic        fs_valid,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_inst,
    input  logic        ds_allowin
);

    typedef enum logic [0:0] {
        ST_REQ  = 1'b0,
        ST_WAIT = 1'b1
    } fetch_state_e;

    fetch_state_e state_r;
    fetch_state_e state_s;
    logic [31:0]  pc_r;
    logic [31:0]  pc_s;
    logic [31:0]  issued_pc_r;
    logic [31:0]  issued_pc_s;
    logic         cancel_r;
    logic         cancel_s;
    logic         fs_valid_r;
    logic         fs_valid_s;
    logic [31:0]  fs_pc_r;
    logic [31:0]  fs_pc_s;
    logic [31:0]  fs_inst_r;
    logic [31:0]  fs_inst_s;

    logic         transfer_s;
    logic         buf_free_s;
    logic         req_s;
    logic         accept_s;

    // Handshake qualifiers; req is gated by resetn so it stays low throughout reset
    always_comb begin
        transfer_s = fs_valid_r & ds_allowin;
        buf_free_s = ~fs_valid_r | transfer_s;
        req_s      = resetn & (state_r == ST_REQ) & buf_free_s;
        accept_s   = req_s & inst_sram_addr_ok;
    end

    // Next-state and datapath; a redirect overrides every buffer and PC update
    always_comb begin
        state_s     = state_r;
        pc_s        = pc_r;
        issued_pc_s = issued_pc_r;
        cancel_s    = cancel_r;
        fs_valid_s  = fs_valid_r;
        fs_pc_s     = fs_pc_r;
        fs_inst_s   = fs_inst_r;
        if (redirect_valid) begin
            pc_s       = redirect_pc;
            fs_valid_s = 1'b0;
            case (state_r)
                ST_REQ: begin
                    // An accepted request still owes a response that must be dropped
                    if (accept_s) begin
                        state_s     = ST_WAIT;
                        issued_pc_s = pc_r;
                        cancel_s    = 1'b1;
                    end else begin
                        state_s     = ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (inst_sram_data_ok) begin
                        state_s  = ST_REQ;
                        cancel_s = 1'b0;
                    end else begin
                        state_s  = ST_WAIT;
                        cancel_s = 1'b1;
                    end
                end
                default: begin
                    state_s = ST_REQ;
                end
            endcase
        end else begin
            if (transfer_s) begin
                fs_valid_s = 1'b0;
            end else begin
                fs_valid_s = fs_valid_r;
            end
            case (state_r)
                ST_REQ: begin
                    if (accept_s) begin
                        state_s     = ST_WAIT;
                        issued_pc_s = pc_r;
                    end else begin
                        state_s     = ST_REQ;
                    end
                end
                ST_WAIT: begin
                    // Returning to REQ here leaves one bubble before the next request
                    if (inst_sram_data_ok) begin
                        state_s = ST_REQ;
                        if (cancel_r) begin
                            cancel_s   = 1'b0;
                        end else begin
                            fs_valid_s = 1'b1;
                            fs_pc_s    = issued_pc_r;
                            fs_inst_s  = inst_sram_rdata;
                            pc_s       = issued_pc_r + 32'd4;
                        end
                    end else begin
                        state_s = ST_WAIT;
                    end
                end
                default: begin
                    state_s = ST_REQ;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r     <= ST_REQ;
            pc_r        <= RESET_PC;
            issued_pc_r <= RESET_PC;
            cancel_r    <= 1'b0;
            fs_valid_r  <= 1'b0;
            fs_pc_r     <= 32'h0000_0000;
            fs_inst_r   <= 32'h0000_0000;
        end else begin
            state_r     <= state_s;
            pc_r        <= pc_s;
            issued_pc_r <= issued_pc_s;
            cancel_r    <= cancel_s;
            fs_valid_r  <= fs_valid_s;
            fs_pc_r     <= fs_pc_s;
            fs_inst_r   <= fs_inst_s;
        end
    end

    assign inst_sram_req   = req_s;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wstrb = 4'b0000;
    assign inst_sram_addr  = pc_r;
    assign inst_sram_wdata = 32'h0000_0000;
    assign fs_valid        = fs_valid_r;
    assign fs_pc           = fs_pc_r;
    assign fs_inst         = fs_inst_r;

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Bench for inst_fetch_stage: latency-configurable memory responder, directed fetch
// scenarios and a randomized phase scored against an expected PC-stream queue.
module tb_inst_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'hbfc0_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok = 1'b0;
    logic        inst_sram_data_ok = 1'b0;
    logic [31:0] inst_sram_rdata = 32'h0;
    logic        fs_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;
    logic        ds_allowin = 1'b0;

    inst_fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .resetn(resetn),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .fs_valid(fs_valid), .fs_pc(fs_pc), .fs_inst(fs_inst),
        .ds_allowin(ds_allowin)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass = 0;

    task automatic chk(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9e37_79b9) ^ 32'h1357_9bdf;
    endfunction

    // Memory responder state and logs
    int          addr_lat_min = 1, addr_lat_max = 1, data_lat_min = 2, data_lat_max = 2;
    int          cur_alat = 1, wcnt = 0, rcnt = 0;
    bit          pend = 1'b0;
    logic [31:0] raddr = 32'h0;
    logic [31:0] acc_log[$];
    int          acc_cyc[$];
    int          dok_cyc[$];

    // Reference stream and transfer logs
    logic [31:0] exp_q[$];
    logic [31:0] xfer_log[$];
    int          xfer_cyc[$];
    int          n_xfer = 0;

    task automatic exp_restart(input logic [31:0] pc);
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(pc + 32'(i) * 32'd4);
    endtask

    function automatic logic [31:0] get_acc(input int i);
        return (i < acc_log.size()) ? acc_log[i] : 32'hdead_beef;
    endfunction

    function automatic logic [31:0] get_xfer(input int i);
        return (i < xfer_log.size()) ? xfer_log[i] : 32'hdead_beef;
    endfunction

    initial begin : memory
        forever begin
            @(negedge clk);
            #1;
            inst_sram_addr_ok = 1'b0;
            inst_sram_data_ok = 1'b0;
            if (!resetn) begin
                pend = 1'b0; wcnt = 0; rcnt = 0; cur_alat = addr_lat_min;
            end else begin
                if (pend) begin
                    if (rcnt == 0) begin
                        inst_sram_data_ok = 1'b1;
                        inst_sram_rdata   = mem_word(raddr);
                        pend = 1'b0;
                        dok_cyc.push_back(cyc);
                    end else begin
                        rcnt--;
                    end
                end
                if (inst_sram_req) begin
                    if (wcnt >= cur_alat) begin
                        chk("single_outstanding", !pend, 32'(pend), 32'h0);
                        chk("tie_offs", inst_sram_wr == 1'b0 && inst_sram_size == 2'b10 &&
                            inst_sram_wstrb == 4'b0000 && inst_sram_wdata == 32'h0,
                            {25'd0, inst_sram_wr, inst_sram_size, inst_sram_wstrb}, 32'h20);
                        inst_sram_addr_ok = 1'b1;
                        pend  = 1'b1;
                        rcnt  = int'($urandom_range(data_lat_max, data_lat_min)) - 1;
                        raddr = inst_sram_addr;
                        acc_log.push_back(inst_sram_addr);
                        acc_cyc.push_back(cyc);
                        wcnt = 0;
                        cur_alat = int'($urandom_range(addr_lat_max, addr_lat_min));
                    end else begin
                        wcnt++;
                    end
                end
            end
        end
    end

    initial begin : monitor
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #3;
            if (resetn) begin
                if (fs_valid && !ds_allowin)
                    chk("no_req_while_full", !inst_sram_req, 32'(inst_sram_req), 32'h0);
                if (fs_valid && ds_allowin && !redirect_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("scoreboard_empty", 1'b0, fs_pc, 32'h0);
                    end else begin
                        e = exp_q.pop_front();
                        if (exp_q.size() < 4) exp_q.push_back(exp_q[$] + 32'd4);
                        chk("xfer_pc", fs_pc === e, fs_pc, e);
                        chk("xfer_inst", fs_inst === mem_word(e), fs_inst, mem_word(e));
                    end
                    xfer_log.push_back(fs_pc);
                    xfer_cyc.push_back(cyc);
                    n_xfer++;
                end
            end
        end
    end

    task automatic set_lat(input int amin, input int amax, input int dmin, input int dmax);
        addr_lat_min = amin; addr_lat_max = amax; data_lat_min = dmin; data_lat_max = dmax;
    endtask

    task automatic do_reset(input bit check_rst, input bit allow);
        @(negedge clk);
        resetn = 1'b0; redirect_valid = 1'b0; ds_allowin = allow;
        repeat (3) @(negedge clk);
        if (check_rst) begin
            #3;
            chk("rst_req", inst_sram_req == 1'b0, 32'(inst_sram_req), 32'h0);
            chk("rst_fs_valid", fs_valid == 1'b0, 32'(fs_valid), 32'h0);
            chk("rst_fs_pc", fs_pc == 32'h0, fs_pc, 32'h0);
            chk("rst_fs_inst", fs_inst == 32'h0, fs_inst, 32'h0);
        end
        @(negedge clk);
        acc_log.delete(); acc_cyc.delete(); dok_cyc.delete();
        xfer_log.delete(); xfer_cyc.delete();
        exp_restart(RESET_PC);
        resetn = 1'b1;
    endtask

    task automatic wait_acc(input int n, input string name);
        int k = 0;
        while (acc_log.size() < n && k < 200) begin @(negedge clk); k++; end
        if (acc_log.size() < n) chk(name, 1'b0, 32'(acc_log.size()), 32'(n));
    endtask

    task automatic wait_xfer(input int n, input string name);
        int k = 0;
        while (xfer_log.size() < n && k < 200) begin @(negedge clk); k++; end
        if (xfer_log.size() < n) chk(name, 1'b0, 32'(xfer_log.size()), 32'(n));
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int          k;
        int          base;
        int          bad;
        logic [31:0] r;
        logic [31:0] npc;

        // 1: sequential fetch with fixed latencies
        set_lat(1, 1, 2, 2);
        do_reset(1'b1, 1'b1);
        wait_acc(3, "t1_acc_timeout");
        wait_xfer(3, "t1_xfer_timeout");
        chk("t1_addr0", get_acc(0) == 32'hbfc0_0000, get_acc(0), 32'hbfc0_0000);
        chk("t1_addr1", get_acc(1) == 32'hbfc0_0004, get_acc(1), 32'hbfc0_0004);
        chk("t1_addr2", get_acc(2) == 32'hbfc0_0008, get_acc(2), 32'hbfc0_0008);
        if (acc_cyc.size() >= 2)
            chk("t1_req_spacing", acc_cyc[1] - acc_cyc[0] == 4, 32'(acc_cyc[1] - acc_cyc[0]), 32'd4);
        if (xfer_cyc.size() >= 1 && dok_cyc.size() >= 1)
            chk("t1_latency", xfer_cyc[0] == dok_cyc[0] + 1, 32'(xfer_cyc[0] - dok_cyc[0]), 32'd1);

        // 2: decode stalled, buffer holds and no further request
        do_reset(1'b0, 1'b0);
        k = 0;
        do begin @(negedge clk); #3; k++; end while (!fs_valid && k < 50);
        chk("t2_filled", fs_valid == 1'b1, 32'(fs_valid), 32'h1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #3;
            if (!(fs_valid && fs_pc == 32'hbfc0_0000 && fs_inst == mem_word(32'hbfc0_0000))) bad++;
        end
        chk("t2_stable", bad == 0, 32'(bad), 32'h0);
        chk("t2_one_req", acc_log.size() == 1, 32'(acc_log.size()), 32'h1);
        @(negedge clk);
        ds_allowin = 1'b1;
        wait_acc(2, "t2_acc_timeout");
        chk("t2_next_addr", get_acc(1) == 32'hbfc0_0004, get_acc(1), 32'hbfc0_0004);

        // 3: redirect while waiting for bfc00004
        do_reset(1'b0, 1'b1);
        wait_acc(2, "t3_acc_timeout");
        #2;
        redirect_pc = 32'h8000_1000; redirect_valid = 1'b1; exp_restart(32'h8000_1000);
        @(negedge clk);
        redirect_valid = 1'b0;
        wait_acc(3, "t3_acc2_timeout");
        chk("t3_redirect_addr", get_acc(2) == 32'h8000_1000, get_acc(2), 32'h8000_1000);
        wait_xfer(2, "t3_xfer_timeout");
        chk("t3_first_xfer", get_xfer(0) == 32'hbfc0_0000, get_xfer(0), 32'hbfc0_0000);
        chk("t3_after_redirect", get_xfer(1) == 32'h8000_1000, get_xfer(1), 32'h8000_1000);

        // 4: redirect with data_ok in the same cycle, wrapping target
        do_reset(1'b0, 1'b1);
        k = 0;
        do begin @(negedge clk); #2; k++; end while (!inst_sram_data_ok && k < 50);
        chk("t4_saw_data_ok", inst_sram_data_ok == 1'b1, 32'(inst_sram_data_ok), 32'h1);
        redirect_pc = 32'hffff_fffc; redirect_valid = 1'b1; exp_restart(32'hffff_fffc);
        @(negedge clk);
        redirect_valid = 1'b0;
        #3;
        chk("t4_req_next", inst_sram_req == 1'b1 && inst_sram_addr == 32'hffff_fffc,
            inst_sram_addr, 32'hffff_fffc);
        wait_acc(3, "t4_acc_timeout");
        chk("t4_addr_target", get_acc(1) == 32'hffff_fffc, get_acc(1), 32'hffff_fffc);
        chk("t4_addr_wrap", get_acc(2) == 32'h0000_0000, get_acc(2), 32'h0000_0000);
        wait_xfer(2, "t4_xfer_timeout");
        chk("t4_xfer0", get_xfer(0) == 32'hffff_fffc, get_xfer(0), 32'hffff_fffc);
        chk("t4_xfer1", get_xfer(1) == 32'h0000_0000, get_xfer(1), 32'h0000_0000);

        // 5: redirect on addr_ok, then a second redirect before the response
        set_lat(1, 1, 4, 4);
        do_reset(1'b0, 1'b1);
        k = 0;
        do begin @(negedge clk); #2; k++; end while (!(inst_sram_req && inst_sram_addr_ok) && k < 50);
        redirect_pc = 32'h8000_2000; redirect_valid = 1'b1; exp_restart(32'h8000_2000);
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        #2;
        chk("t5_no_data_yet", inst_sram_data_ok == 1'b0, 32'(inst_sram_data_ok), 32'h0);
        redirect_pc = 32'h8000_3000; redirect_valid = 1'b1; exp_restart(32'h8000_3000);
        @(negedge clk);
        redirect_valid = 1'b0;
        wait_acc(2, "t5_acc_timeout");
        chk("t5_resume_addr", get_acc(1) == 32'h8000_3000, get_acc(1), 32'h8000_3000);
        wait_xfer(1, "t5_xfer_timeout");
        chk("t5_first_xfer", get_xfer(0) == 32'h8000_3000, get_xfer(0), 32'h8000_3000);

        // 6: reset asserted while waiting
        set_lat(1, 1, 3, 3);
        do_reset(1'b0, 1'b1);
        wait_acc(2, "t6_acc_timeout");
        resetn = 1'b0;
        @(negedge clk);
        #3;
        chk("t6_req_low", inst_sram_req == 1'b0, 32'(inst_sram_req), 32'h0);
        chk("t6_fs_valid_low", fs_valid == 1'b0, 32'(fs_valid), 32'h0);
        @(negedge clk);
        acc_log.delete(); acc_cyc.delete(); dok_cyc.delete();
        xfer_log.delete(); xfer_cyc.delete();
        exp_restart(RESET_PC);
        resetn = 1'b1;
        wait_acc(1, "t6_acc_timeout2");
        chk("t6_restart_addr", get_acc(0) == RESET_PC, get_acc(0), RESET_PC);
        wait_xfer(1, "t6_xfer_timeout");
        chk("t6_restart_xfer", get_xfer(0) == RESET_PC, get_xfer(0), RESET_PC);

        // Randomized phase: random latencies, stalls and redirects
        set_lat(0, 2, 1, 4);
        do_reset(1'b0, 1'b1);
        base = n_xfer;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            ds_allowin = ($urandom_range(9, 0) < 7);
            redirect_valid = 1'b0;
            if ($urandom_range(29, 0) == 0) begin
                r = $urandom;
                npc = ($urandom_range(3, 0) == 0) ? 32'hffff_fff0 : {r[31:2], 2'b00};
                redirect_pc = npc;
                redirect_valid = 1'b1;
                exp_restart(npc);
            end
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        ds_allowin = 1'b1;
        repeat (20) @(negedge clk);
        chk("rand_progress", (n_xfer - base) > 100, 32'(n_xfer - base), 32'd100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
